sm_tc_convert_pipe: RTL and testbench
=====================================

# sm_tc_convert_pipe

Multi-lane, pipelined, bidirectional converter between sign-magnitude and two's-complement message formats for the LDPC decoder datapath. It sits between the channel/CNU message memories, which hold sign-magnitude values, and the VNU adders, which work in two's complement. The mode is selected per beat. Values that cannot be represented in the target format saturate, with a per-lane flag and a running saturation count. The block uses valid/ready handshakes on both sides, with two register stages.

## Interface
- DATA_WIDTH, 5: bits per message, sign included; minimum 2.
- LANES, 8: messages per beat.
- CNT_WIDTH, 16: width of the saturation-event counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_mode  in  1  0 = sign-magnitude→two's complement (S2T), 1 = two's complement→sign-magnitude (T2S).
- in_data  in  LANES*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  LANES*DATA_WIDTH  converted lanes, same packing.
- out_sat  out  LANES  per-lane saturation flag, aligned with out_data.
- sat_clr  in  1  synchronous clear of sat_count.
- sat_count  out  CNT_WIDTH  count of accepted output beats with any out_sat bit set.

## Operation
- W = DATA_WIDTH. For each lane, s = x[W-1] and m = x[W-2:0].
- S2T:
  - s=0: out = x.
  - s=1, m≠0: out = two's-complement negation of {0,m} in W bits. Example, W=5: 10011 → 11101.
  - s=1, m=0 (negative zero): out = 0, sat = 0.
- T2S:
  - s=0: out = x.
  - s=1, x ≠ 1 followed by W-1 zeros: out = {1, low W-1 bits of −x}. Example: 11101 → 10011.
  - x = 1 followed by W-1 zeros (most negative value): out = all ones (−(2^(W-1)−1)), sat = 1.
- S2T never sets sat.
- Mode travels with its beat, so back-to-back beats may use different modes.
- Lanes are independent. Conversion is pure per-lane logic between stage A and stage B.
- sat_count update, per cycle:
  - If sat_clr = 1: sat_count ← 0. Clear wins over a simultaneous increment.
  - Else, if out_valid & out_ready & |out_sat: increment by 1, holding at 2^CNT_WIDTH−1 (no wrap).

## Timing
- Stage A registers in_data and in_mode. Stage B registers the converted data and sat flags. out_* are driven directly from stage B.
- Latency: a beat accepted at edge n appears on out_* after edge n+1 (out_valid high in cycle n+1) when out_ready was held high. Throughput is 1 beat/cycle.
- Handshake rules:
  - b_adv = !b_valid | out_ready.
  - a_adv = !a_valid | b_adv.
  - in_ready = !rst & a_adv. This is combinational from out_ready; there is no skid buffer.
- Transfers occur only when valid & ready.
- While out_valid=1 and out_ready=0, out_data and out_sat hold stable.
- in_data and in_mode are ignored when in_valid=0.
- Reset values: out_valid=0, out_data=0, out_sat=0, sat_count=0, both stage valids 0. in_ready=0 during rst and 1 in the first cycle after rst falls.
- Reset mid-operation drops all in-flight beats; no output beat survives reset.
- Pipeline full with out_ready=0: in_ready=0. When out_ready rises, in_ready rises in the same cycle, and a new beat enters while the stage B beat leaves.

## Structure
- Shared package ldpc_fmt_pkg holds:
  - mode constants MODE_S2T=1'b0 and MODE_T2S=1'b1;
  - the shared DATA_WIDTH default, reused by VNU/CNU blocks.
- Sub-module sm_tc_lane: a combinational single-lane converter (in, mode → out, sat), instantiated LANES times with a generate loop.
- The top level holds the pipeline registers, the handshake logic and sat_count.

## Test plan
- Reset, then stream every 5-bit code in S2T, then in T2S, with out_ready=1. Required: bit-exact match to a reference model; latency 2; one beat per cycle. Spot checks: S2T 10000→00000 with sat=0; T2S 10000→11111 with sat=1.
- Alternate modes every beat, with lanes set to 10011 (S2T) then 11101 (T2S). Required: outputs 11101 then 10011; no cross-beat mode leakage.
- Hold out_ready=0 for 5 cycles with 3 beats offered. Required: 2 beats accepted, then in_ready=0; out_data stable throughout. Release: beats exit in order with none lost or duplicated.
- Send 4 T2S beats, each with one lane at 10000, and assert sat_clr in the same cycle as the 3rd accepted output. Required: sat_count 1, 2, 0, 1.
- Force CNT_WIDTH=2 and send 5 saturating beats. Required: sat_count holds at 3.
- Assert rst with 2 beats in flight. Required: out_valid=0 next cycle; sat_count=0; no stale beat ever emitted.

Source files
------------

// File: rtl/ldpc_fmt_pkg.sv
// ldpc_fmt_pkg: message-format constants shared by the LDPC datapath blocks
package ldpc_fmt_pkg;
    localparam logic MODE_S2T   = 1'b0;
    localparam logic MODE_T2S   = 1'b1;
    localparam int   DATA_WIDTH = 5;
endpackage

// File: rtl/sm_tc_convert_pipe_lane.sv
// sm_tc_lane: single-lane sign-magnitude <-> two's-complement converter
module sm_tc_lane
    import ldpc_fmt_pkg::*;
#(
    parameter int W = DATA_WIDTH
) (
    input  logic [W-1:0] x,
    input  logic         mode,
    output logic [W-1:0] y,
    output logic         sat
);
    logic [W-1:0] mag_neg;
    logic [W-1:0] x_neg;
    logic         is_min;
    // negative zero negates to zero, so S2T needs no special case
    always_comb begin
        mag_neg = -{1'b0, x[W-2:0]};
        x_neg   = -x;
        is_min  = x == {1'b1, {(W-1){1'b0}}};
        sat     = mode == MODE_T2S && is_min;
        y       = !x[W-1] ? x : mode == MODE_S2T ? mag_neg : is_min ? '1 : {1'b1, x_neg[W-2:0]};
    end
endmodule

// File: rtl/sm_tc_convert_pipe.sv
// sm_tc_convert_pipe: two-stage valid/ready multi-lane SM/TC converter with saturation count
module sm_tc_convert_pipe
    import ldpc_fmt_pkg::*;
#(
    parameter int DATA_WIDTH = ldpc_fmt_pkg::DATA_WIDTH,
    parameter int LANES      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_mode,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic [LANES-1:0]            out_sat,
    input  logic                        sat_clr,
    output logic [CNT_WIDTH-1:0]        sat_count
);
    logic                        a_valid;
    logic                        a_mode;
    logic [LANES*DATA_WIDTH-1:0] a_data;
    logic                        b_valid;
    logic [LANES*DATA_WIDTH-1:0] b_data;
    logic [LANES-1:0]            b_sat;
    logic [LANES*DATA_WIDTH-1:0] conv;
    logic [LANES-1:0]            conv_sat;
    logic                        a_adv;
    logic                        b_adv;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sm_tc_lane #(.W(DATA_WIDTH)) u_lane (
            .x   (a_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .mode(a_mode),
            .y   (conv[i*DATA_WIDTH +: DATA_WIDTH]),
            .sat (conv_sat[i])
        );
    end

    // a stage advances whenever the stage ahead of it can take or pass its beat
    always_comb begin
        b_adv    = !b_valid || out_ready;
        a_adv    = !a_valid || b_adv;
        in_ready = !rst && a_adv;
    end

    // stage A: capture the raw beat and its mode together
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
            a_mode  <= MODE_S2T;
            a_data  <= '0;
        end else if (a_adv) begin
            a_valid <= in_valid;
            if (in_valid) begin
                a_mode <= in_mode;
                a_data <= in_data;
            end
        end
    end

    // stage B: capture converted lanes; holds while stalled downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            b_valid <= 1'b0;
            b_data  <= '0;
            b_sat   <= '0;
        end else if (b_adv) begin
            b_valid <= a_valid;
            if (a_valid) begin
                b_data <= conv;
                b_sat  <= conv_sat;
            end
        end
    end

    // count delivered beats carrying any saturated lane; clear has priority, no wrap
    always_ff @(posedge clk) begin
        if (rst || sat_clr)
            sat_count <= '0;
        else if (b_valid && out_ready && |b_sat && sat_count != '1)
            sat_count <= sat_count + CNT_WIDTH'(1);
    end

    assign out_valid = b_valid;
    assign out_data  = b_data;
    assign out_sat   = b_sat;
endmodule

// File: tb/tb_sm_tc_convert_pipe.sv
// tb_sm_tc_convert_pipe: directed self-checking bench with scoreboard for sm_tc_convert_pipe
module tb_sm_tc_convert_pipe;
    localparam int W = 5;
    localparam int L = 8;

    typedef struct {
        logic [L*W-1:0] d;
        logic [L-1:0]   s;
        int             cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           in_mode = 1'b0;
    logic [L*W-1:0] in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [L*W-1:0] out_data;
    logic [L-1:0]   out_sat;
    logic           sat_clr = 1'b0;
    logic [15:0]    sat_count;
    logic           c2_in_ready;
    logic           c2_out_valid;
    logic [L*W-1:0] c2_out_data;
    logic [L-1:0]   c2_out_sat;
    logic [1:0]     c2_sat_count;

    int             n_checks = 0;
    int             n_fail   = 0;
    int             cyc      = 0;
    int             out_cnt  = 0;
    int             n_out    = 0;
    logic           last_acc;
    logic           last_rdy;
    logic           lat_chk   = 1'b0;
    logic           sat_phase = 1'b0;
    logic [L*W-1:0] nxt_d;
    logic [L-1:0]   nxt_s;
    logic [L*W-1:0] hold;
    int             sat_exp[4] = '{1, 2, 0, 1};
    exp_t           exp_q[$];

    sm_tc_convert_pipe #(.DATA_WIDTH(W), .LANES(L), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .sat_clr(sat_clr), .sat_count(sat_count)
    );

    sm_tc_convert_pipe #(.DATA_WIDTH(W), .LANES(L), .CNT_WIDTH(2)) dut_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c2_in_ready), .in_mode(in_mode),
        .in_data(in_data), .out_valid(c2_out_valid), .out_ready(out_ready), .out_data(c2_out_data),
        .out_sat(c2_out_sat), .sat_clr(sat_clr), .sat_count(c2_sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference: arithmetic on signed integers rather than bit manipulation
    function automatic void model(input logic [L*W-1:0] d, input logic m,
                                  output logic [L*W-1:0] od, output logic [L-1:0] os);
        logic [W-1:0]  x;
        logic [31:0]   v;
        int            val;
        od = '0;
        os = '0;
        for (int i = 0; i < L; i++) begin
            x = d[i*W +: W];
            if (!m) begin
                val = x[W-1] ? -int'(x[W-2:0]) : int'(x[W-2:0]);
                v = 32'(val);
                od[i*W +: W] = v[W-1:0];
            end else begin
                val = x[W-1] ? int'(x) - (1 << W) : int'(x);
                if (val == -(1 << (W-1))) begin
                    od[i*W +: W] = '1;
                    os[i] = 1'b1;
                end else if (val < 0) begin
                    v = 32'(-val);
                    od[i*W +: W] = {1'b1, v[W-2:0]};
                end else begin
                    od[i*W +: W] = x;
                end
            end
        end
    endfunction

    // one clock: sample handshakes mid-cycle, score, then step past the edge
    task automatic tick();
        logic xfer;
        exp_t e;
        #1;
        last_rdy = in_ready;
        last_acc = in_valid && in_ready;
        xfer = out_valid && out_ready;
        if (xfer) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(out_data), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 64'(out_data), 64'(e.d));
                check("out_sat", 64'(out_sat), 64'(e.s));
                if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'd2);
            end
        end
        if (last_acc) exp_q.push_back('{d: nxt_d, s: nxt_s, cyc: cyc});
        if (sat_phase) sat_clr = xfer && n_out == 2;
        @(posedge clk);
        #1;
        cyc++;
        if (sat_phase && xfer) begin
            check("sat_count_seq", 64'(sat_count), 64'(sat_exp[n_out]));
            n_out++;
        end
        if (sat_phase) sat_clr = 1'b0;
    endtask

    task automatic offer(input logic [L*W-1:0] d, input logic m);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        model(d, m, nxt_d, nxt_s);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int n = 0; n < 12 && exp_q.size() != 0; n++) tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [L*W-1:0] d;
        int idx;
        // reset state
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_sat", 64'(out_sat), 64'd0);
        check("rst_sat_count", 64'(sat_count), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // every code in S2T then T2S at full rate
        out_ready = 1'b1;
        lat_chk = 1'b1;
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < L; i++) d[i*W +: W] = W'(k*8 + i);
                offer(d, m[0]);
                tick();
                check("stream_ready", 64'(last_rdy), 64'd1);
            end
        drain();
        lat_chk = 1'b0;
        check("stream_outs", 64'(out_cnt), 64'd8);

        // negative-zero and most-negative spot checks with hand-computed results
        in_valid = 1'b1; in_mode = 1'b0; in_data = {L{5'b10000}};
        nxt_d = '0; nxt_s = '0;
        tick();
        in_mode = 1'b1; nxt_d = {L{5'b11111}}; nxt_s = '1;
        tick();
        drain();

        // mode alternates every beat
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_mode  = k[0];
            in_data  = k[0] ? {L{5'b11101}} : {L{5'b10011}};
            nxt_d    = k[0] ? {L{5'b10011}} : {L{5'b11101}};
            nxt_s    = '0;
            tick();
        end
        drain();

        // backpressure: two beats fit, third waits, output frozen
        out_ready = 1'b0;
        out_cnt = 0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            offer({L{W'(idx + 3)}} ^ 40'h12_3456_789A, 1'b1);
            tick();
            if (last_acc) idx++;
            if (c == 1) hold = out_data;
            if (c >= 2) begin
                check("bp_in_ready", 64'(last_rdy), 64'd0);
                check("bp_hold_data", 64'(out_data), 64'(hold));
                check("bp_out_valid", 64'(out_valid), 64'd1);
            end
        end
        check("bp_accepted", 64'(idx), 64'd2);
        out_ready = 1'b1;
        for (int c = 0; c < 5 && idx < 3; c++) begin
            offer({L{W'(idx + 3)}} ^ 40'h12_3456_789A, 1'b1);
            tick();
            if (last_acc) idx++;
        end
        drain();
        check("bp_out_count", 64'(out_cnt), 64'd3);

        // sat_count with a clear coinciding with the third saturating output
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("clr_sat_count", 64'(sat_count), 64'd0);
        d = {L{5'b00001}};
        d[3*W +: W] = 5'b10000;
        sat_phase = 1'b1;
        n_out = 0;
        for (int k = 0; k < 4; k++) begin
            offer(d, 1'b1);
            tick();
        end
        drain();
        sat_phase = 1'b0;
        check("sat_outs", 64'(n_out), 64'd4);

        // narrow counter saturates instead of wrapping
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            offer(d, 1'b1);
            tick();
        end
        drain();
        check("c2_hold", 64'(c2_sat_count), 64'd3);
        check("c16_count", 64'(sat_count), 64'd5);

        // reset with two beats in flight
        offer({L{5'b00111}}, 1'b0);
        tick();
        offer({L{5'b10111}}, 1'b0);
        out_ready = 1'b0;
        tick();
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        tick();
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sat_count", 64'(sat_count), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        out_cnt = 0;
        for (int c = 0; c < 5; c++) tick();
        check("no_stale_beats", 64'(out_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
